// File: rtl/org_rd_arb_if.sv
// Read-port bundle between the two requesters, the arbiter and the
// original-pixel buffer.
interface org_rd_arb_if;
  logic         r0_req_i;
  logic         r0_ren_i;
  logic         r0_sel_i;
  logic [1:0]   r0_size_i;
  logic [3:0]   r0_4x4_x_i;
  logic [3:0]   r0_4x4_y_i;
  logic [4:0]   r0_idx_i;
  logic         r0_gnt_o;
  logic         r0_vld_o;

  logic         r1_req_i;
  logic         r1_ren_i;
  logic         r1_sel_i;
  logic [1:0]   r1_size_i;
  logic [3:0]   r1_4x4_x_i;
  logic [3:0]   r1_4x4_y_i;
  logic [4:0]   r1_idx_i;
  logic         r1_gnt_o;
  logic         r1_vld_o;

  logic         md_ren_o;
  logic         md_sel_o;
  logic [1:0]   md_size_o;
  logic [3:0]   md_4x4_x_o;
  logic [3:0]   md_4x4_y_o;
  logic [4:0]   md_idx_o;
  logic [255:0] md_data_i;
  logic [255:0] rdata_o;
  logic         busy_o;

  modport slave (
    input  r0_req_i, r0_ren_i, r0_sel_i, r0_size_i,
    input  r0_4x4_x_i, r0_4x4_y_i, r0_idx_i,
    input  r1_req_i, r1_ren_i, r1_sel_i, r1_size_i,
    input  r1_4x4_x_i, r1_4x4_y_i, r1_idx_i,
    input  md_data_i,
    output r0_gnt_o, r0_vld_o, r1_gnt_o, r1_vld_o,
    output md_ren_o, md_sel_o, md_size_o,
    output md_4x4_x_o, md_4x4_y_o, md_idx_o,
    output rdata_o, busy_o
  );

  modport master (
    output r0_req_i, r0_ren_i, r0_sel_i, r0_size_i,
    output r0_4x4_x_i, r0_4x4_y_i, r0_idx_i,
    output r1_req_i, r1_ren_i, r1_sel_i, r1_size_i,
    output r1_4x4_x_i, r1_4x4_y_i, r1_idx_i,
    output md_data_i,
    input  r0_gnt_o, r0_vld_o, r1_gnt_o, r1_vld_o,
    input  md_ren_o, md_sel_o, md_size_o,
    input  md_4x4_x_o, md_4x4_y_o, md_idx_o,
    input  rdata_o, busy_o
  );
endinterface

// File: rtl/org_rd_arb.sv
// Burst-granular round-robin arbiter for the LCU original-pixel buffer
// read port, with optional preemption and latency-matched data tagging.
module org_rd_arb #(
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 0,
  parameter int BCNT_W    = 6
) (
  input logic       clk,
  input logic       rst,
  org_rd_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [31:0] MB = 32'(MAX_BURST);
  localparam bit PREEMPT = (MAX_BURST > 0);

  state_t              state;
  state_t              state_nxt;
  logic                last;
  logic [BCNT_W-1:0]   bcnt;
  logic [BCNT_W:0]     cnt_ext;
  logic                lim;
  logic                fwd;
  logic [RD_LAT-1:0]   tag_v;
  logic [RD_LAT-1:0]   tag_o;

  assign fwd = ((state == OWN0) & bus.r0_ren_i)
             | ((state == OWN1) & bus.r1_ren_i);

  // Limit counts the beat being forwarded now, so the owner gets exactly MAX_BURST.
  assign cnt_ext = {1'b0, bcnt} + {{BCNT_W{1'b0}}, fwd};
  assign lim = PREEMPT && (32'(cnt_ext) >= MB);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.r0_req_i && bus.r1_req_i)
          state_nxt = last ? OWN0 : OWN1;
        else if (bus.r0_req_i)
          state_nxt = OWN0;
        else if (bus.r1_req_i)
          state_nxt = OWN1;
      end
      OWN0: begin
        if (lim && bus.r1_req_i)
          state_nxt = OWN1;
        else if (!bus.r0_req_i)
          state_nxt = bus.r1_req_i ? OWN1 : IDLE;
      end
      OWN1: begin
        if (lim && bus.r0_req_i)
          state_nxt = OWN0;
        else if (!bus.r1_req_i)
          state_nxt = bus.r0_req_i ? OWN0 : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.r0_gnt_o   = 1'b0;
    bus.r1_gnt_o   = 1'b0;
    bus.md_sel_o   = 1'b0;
    bus.md_size_o  = 2'd0;
    bus.md_4x4_x_o = 4'd0;
    bus.md_4x4_y_o = 4'd0;
    bus.md_idx_o   = 5'd0;
    unique case (1'b1)
      (state == OWN0): begin
        bus.r0_gnt_o   = 1'b1;
        bus.md_sel_o   = bus.r0_sel_i;
        bus.md_size_o  = bus.r0_size_i;
        bus.md_4x4_x_o = bus.r0_4x4_x_i;
        bus.md_4x4_y_o = bus.r0_4x4_y_i;
        bus.md_idx_o   = bus.r0_idx_i;
      end
      (state == OWN1): begin
        bus.r1_gnt_o   = 1'b1;
        bus.md_sel_o   = bus.r1_sel_i;
        bus.md_size_o  = bus.r1_size_i;
        bus.md_4x4_x_o = bus.r1_4x4_x_i;
        bus.md_4x4_y_o = bus.r1_4x4_y_i;
        bus.md_idx_o   = bus.r1_idx_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last  <= 1'b1;
      bcnt  <= '0;
      tag_v <= '0;
      tag_o <= '0;
    end else begin
      if (state_nxt != state)
        bcnt <= '0;
      else if (fwd && (bcnt != '1))
        bcnt <= bcnt + BCNT_W'(1);
      if ((state_nxt == OWN0) && (state != OWN0))
        last <= 1'b0;
      else if ((state_nxt == OWN1) && (state != OWN1))
        last <= 1'b1;
      tag_v[0] <= fwd;
      tag_o[0] <= (state == OWN1);
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_o[i] <= tag_o[i-1];
      end
    end
  end

  assign bus.md_ren_o = fwd;
  assign bus.r0_vld_o = tag_v[RD_LAT-1] & ~tag_o[RD_LAT-1];
  assign bus.r1_vld_o = tag_v[RD_LAT-1] &  tag_o[RD_LAT-1];
  assign bus.rdata_o  = bus.md_data_i;
  assign bus.busy_o   = (state != IDLE) | (|tag_v);

endmodule
